// File: rtl/a2d_intf.sv
// SPI master for the external A2D: each nxt request runs a dummy-then-real
// 16-bit conversion on the next round-robin channel and latches the 12-bit result.
module a2d_intf #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

  localparam logic [SCLK_DIV_W-1:0] DIV_MAX  = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = DIV_MAX >> 1;

  state_t                  state_q, state_d;
  logic [SCLK_DIV_W-1:0]   div_q, div_d;
  logic [4:0]              rise_cnt_q, rise_cnt_d;
  logic [15:0]             tx_q, tx_d;
  logic [15:0]             rx_q, rx_d;
  logic                    ss_n_q, ss_n_d;
  logic                    gap_q, gap_d;
  logic [1:0]              rr_q, rr_d;
  logic [3:0][11:0]        rd_q, rd_d;
  logic                    cmplt_q, cmplt_d;

  logic [2:0]  chnl;
  logic [15:0] cmd;
  logic        xfer_done;

  always_comb begin
    unique case (rr_q)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd4;
      2'd2:    chnl = 3'd5;
      default: chnl = 3'd6;
    endcase
  end

  assign cmd       = {2'b00, chnl, 11'h000};
  assign xfer_done = (rise_cnt_q == 5'd16);

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    rise_cnt_d = rise_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    ss_n_d     = ss_n_q;
    gap_d      = gap_q;
    rr_d       = rr_q;
    rd_d       = rd_q;
    cmplt_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d    = TX1;
          ss_n_d     = 1'b0;
          div_d      = '0;
          rise_cnt_d = '0;
          tx_d       = cmd;
        end
      end
      TX1, TX2: begin
        if (xfer_done) begin
          ss_n_d  = 1'b1;
          gap_d   = 1'b0;
          state_d = (state_q == TX1) ? GAP : DONE;
        end else begin
          div_d = div_q + 1'b1;
          // Divider wrap is the SCLK rising edge: sample MISO there.
          if (div_q == DIV_MAX) begin
            rise_cnt_d = rise_cnt_q + 1'b1;
            if (state_q == TX2) rx_d = {rx_q[14:0], MISO};
          end
          // MSB is already on MOSI when SS_n falls, so the first fall keeps it.
          if (div_q == DIV_FALL && rise_cnt_q != 5'd0) tx_d = {tx_q[14:0], 1'b0};
        end
      end
      GAP: begin
        if (gap_q) begin
          state_d    = TX2;
          ss_n_d     = 1'b0;
          div_d      = '0;
          rise_cnt_d = '0;
          tx_d       = cmd;
        end else begin
          gap_d = 1'b1;
        end
      end
      DONE: begin
        rd_d[rr_q] = rx_q[11:0];
        rr_d       = rr_q + 1'b1;
        cmplt_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      rise_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ss_n_q     <= 1'b1;
      gap_q      <= 1'b0;
      rr_q       <= '0;
      rd_q       <= '0;
      cmplt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      rise_cnt_q <= rise_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ss_n_q     <= ss_n_d;
      gap_q      <= gap_d;
      rr_q       <= rr_d;
      rd_q       <= rd_d;
      cmplt_q    <= cmplt_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = ss_n_q | ~div_q[SCLK_DIV_W-1];
  assign MOSI      = ~ss_n_q & tx_q[15];
  assign cnv_cmplt = cmplt_q;
  assign lft_ld    = rd_q[0];
  assign rght_ld   = rd_q[1];
  assign steer_pot = rd_q[2];
  assign batt      = rd_q[3];

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural A2D slave, reading model and scoreboard
// queues checked by independent monitors on the falling clock edge.
module tb_a2d_intf;

  localparam int SS_LOW  = 16 * 32 + 1;
  localparam int GAP_CLK = 2;
  localparam int LAT     = SS_LOW + GAP_CLK + SS_LOW + 1;

  typedef struct {
    logic [3:0][11:0] vals;
    int               issue;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, nxt = 1'b0, MISO = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic cnv_cmplt, SS_n, SCLK, MOSI;

  a2d_intf #(.SCLK_DIV_W(5)) dut (
    .clk(clk), .rst(rst), .nxt(nxt),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;
  bit abort = 1'b1, miso_noise = 1'b0;

  logic [15:0] resp_q[$];
  logic [15:0] exp_cmd_q[$];
  exp_t        exp_conv_q[$];
  logic [11:0] m_reg[4];
  int          m_rr = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] cmd_of(input int rr);
    logic [2:0] ch;
    case (rr)
      0:       ch = 3'd0;
      1:       ch = 3'd4;
      2:       ch = 3'd5;
      default: ch = 3'd6;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  // A2D slave: presents response MSB-first, advancing after each SCLK rise.
  logic [15:0] cur_resp, cap;
  int rises, fall_cyc, rise_cyc, txn_idx = 0;
  bit in_txn = 0;
  logic prev_ss = 1'b1, prev_sclk = 1'b1;
  always @(negedge clk) begin
    if (abort || rst_seen) begin
      txn_idx = 0;
      in_txn  = 0;
    end
    if (miso_noise) begin
      MISO = 1'($urandom);
    end else if (prev_ss === 1'b1 && SS_n === 1'b0) begin
      check("resp_avail", 48'(resp_q.size() != 0), 48'd1);
      cur_resp = (resp_q.size() != 0) ? resp_q.pop_front() : 16'h0;
      if (txn_idx == 1) check("gap_clks", 48'(cyc - rise_cyc), 48'(GAP_CLK));
      fall_cyc = cyc;
      rises    = 0;
      cap      = '0;
      in_txn   = 1;
      MISO     = cur_resp[15];
    end else if (in_txn && SS_n === 1'b0 && prev_sclk === 1'b0 && SCLK === 1'b1) begin
      cap = {cap[14:0], MOSI};
      rises++;
      MISO = (rises < 16) ? cur_resp[15-rises] : 1'b0;
    end else if (in_txn && prev_ss === 1'b0 && SS_n === 1'b1) begin
      check("sclk_rises", 48'(rises), 48'd16);
      check("ss_low_clks", 48'(cyc - fall_cyc), 48'(SS_LOW));
      check("mosi_cmd", 48'(cap), (exp_cmd_q.size() != 0) ? 48'(exp_cmd_q.pop_front()) : 'x);
      check("mosi_idle", 48'(MOSI), 48'd0);
      txn_idx  = 1 - txn_idx;
      rise_cyc = cyc;
      in_txn   = 0;
    end
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  // Conversion monitor: compares each cnv_cmplt against the scoreboard.
  logic [47:0] prev_outs = '0;
  logic        prev_cmplt = 1'b0;
  always @(negedge clk) begin
    logic [47:0] outs;
    exp_t        e;
    outs = {batt, steer_pot, rght_ld, lft_ld};
    if (prev_cmplt) check("cmplt_one_clk", 48'(cnv_cmplt), 48'd0);
    if (cnv_cmplt === 1'b1) begin
      check("cmplt_expected", 48'(exp_conv_q.size() != 0), 48'd1);
      if (exp_conv_q.size() != 0) begin
        e = exp_conv_q.pop_front();
        check("lft_ld", 48'(lft_ld), 48'(e.vals[0]));
        check("rght_ld", 48'(rght_ld), 48'(e.vals[1]));
        check("steer_pot", 48'(steer_pot), 48'(e.vals[2]));
        check("batt", 48'(batt), 48'(e.vals[3]));
        check("latency", 48'(cyc - e.issue), 48'(LAT));
      end
    end else if (!rst_seen && !abort && outs !== prev_outs) begin
      check("outputs_stable", outs, prev_outs);
    end
    prev_outs  = outs;
    prev_cmplt = cnv_cmplt;
  end

  task automatic issue_conv(input logic [15:0] resp, output int e);
    exp_t x;
    @(negedge clk);
    resp_q.push_back(16'($urandom));
    resp_q.push_back(resp);
    exp_cmd_q.push_back(cmd_of(m_rr));
    exp_cmd_q.push_back(cmd_of(m_rr));
    m_reg[m_rr] = resp[11:0];
    m_rr = (m_rr + 1) % 4;
    x.vals  = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    x.issue = cyc + 1;
    exp_conv_q.push_back(x);
    e   = cyc + 1;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && exp_conv_q.size() != 0; i++) @(negedge clk);
    check("conv_done_in_time", 48'(exp_conv_q.size()), 48'd0);
    exp_conv_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic conv(input logic [15:0] resp);
    int e;
    issue_conv(resp, e);
    wait_idle();
  endtask

  task automatic apply_reset(input int n, input bit with_nxt);
    @(negedge clk);
    abort      = 1'b1;
    rst        = 1'b1;
    miso_noise = 1'b1;
    nxt        = with_nxt;
    @(posedge clk);
    #1;
    check("rst_ss_n", 48'(SS_n), 48'd1);
    check("rst_sclk", 48'(SCLK), 48'd1);
    @(negedge clk);
    nxt = 1'b0;
    repeat (n - 1) @(negedge clk);
    check("rst_readings", {batt, steer_pot, rght_ld, lft_ld}, 48'h0);
    check("rst_cmplt", 48'(cnv_cmplt), 48'd0);
    resp_q.delete();
    exp_cmd_q.delete();
    exp_conv_q.delete();
    foreach (m_reg[i]) m_reg[i] = 12'h000;
    m_rr       = 0;
    rst        = 1'b0;
    miso_noise = 1'b0;
    MISO       = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b0;
    check("idle_after_rst", 48'(SS_n), 48'd1);
  endtask

  initial begin
    int e;
    logic [15:0] rr_resp[5];
    rr_resp = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555};

    apply_reset(2, 1'b1);

    conv(16'h0ABC);
    check("single_lft", 48'(lft_ld), 48'hABC);

    apply_reset(1, 1'b0);
    foreach (rr_resp[i]) conv(rr_resp[i]);
    check("rr_lft", 48'(lft_ld), 48'h555);
    check("rr_rght", 48'(rght_ld), 48'h222);
    check("rr_steer", 48'(steer_pot), 48'h333);
    check("rr_batt", 48'(batt), 48'h444);

    // Requests while busy (TX1 and GAP) must be dropped.
    issue_conv(16'($urandom), e);
    while (cyc < e + 99) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    while (cyc < e + 513) @(negedge clk);
    check("in_gap", 48'(SS_n), 48'd1);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    wait_idle();

    while (m_rr != 1) conv(16'($urandom));
    conv(16'hF123);
    check("upper_bits", 48'(rght_ld), 48'h123);

    repeat (6) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      conv(16'($urandom));
    end

    issue_conv(16'($urandom), e);
    while (cyc < e + 813) @(negedge clk);
    apply_reset(2, 1'b0);
    conv(16'h0321);
    check("post_rst_lft", 48'(lft_ld), 48'h321);

    check("cmd_q_empty", 48'(exp_cmd_q.size()), 48'd0);
    check("resp_q_empty", 48'(resp_q.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- Producer side of the load-cell/steering interface: the SPI master that converts the external A2D channels and presents registered 12-bit readings.
- Outputs lft_ld, rght_ld, steer_pot and batt, which feed the steering-enable, balance and battery logic.
- Each `nxt` request runs one two-transaction SPI conversion on the next channel in round-robin order, then updates the matching output register.

Parameters:
- SCLK_DIV_W, 5: width of the SCLK divider; SCLK period = 2^SCLK_DIV_W clk cycles (32 by default).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- nxt  input  1  one-clk pulse; starts conversion of the next round-robin channel
- lft_ld  output  12  left load cell reading (A2D channel 0)
- rght_ld  output  12  right load cell reading (A2D channel 4)
- steer_pot  output  12  steering potentiometer reading (A2D channel 5)
- batt  output  12  battery voltage reading (A2D channel 6)
- cnv_cmplt  output  1  one-clk pulse when an output register has just been updated
- SS_n  output  1  SPI slave select, active low
- SCLK  output  1  SPI clock, idles high
- MOSI  output  1  SPI data to the A2D
- MISO  input  1  SPI data from the A2D

Behaviour:
- Clocking and reset: single clock domain; all flops update on posedge clk.
- Reset values (rst=1 at a posedge): lft_ld, rght_ld, steer_pot, batt = 12'h000; cnv_cmplt=0; SS_n=1; SCLK=1; MOSI=0; round-robin index rr=0; state IDLE.
- Reset mid-operation: reset aborts any transaction; SS_n and SCLK are high on the very next clk.
- Round robin: rr 0,1,2,3 selects channel 0,4,5,6 and destination lft_ld, rght_ld, steer_pot, batt.
  - rr increments only on conversion completion; wraps 3->0.
- Command word: {2'b00, chnl[2:0], 11'h000}, i.e. 16'h0000, 16'h2000, 16'h2800, 16'h3000 for channels 0, 4, 5, 6.
- State machine: IDLE -> TX1 -> GAP -> TX2 -> DONE -> IDLE.
  - IDLE: SS_n=1, SCLK=1. nxt=1 -> TX1; SS_n falls on the next clk.
  - TX1: 16-bit transaction sending the command word; MISO data discarded. On completion -> GAP.
  - GAP: SS_n held high for exactly 2 clks -> TX2.
  - TX2: 16-bit transaction resending the same command word; MISO shifted into a 16-bit receive register. On completion -> DONE.
  - DONE (1 clk): selected output <= rx[11:0] (rx[15:12] ignored); cnv_cmplt=1 for this clk only; rr advances; -> IDLE.
  - Total conversion latency from nxt to cnv_cmplt is fixed: verifier checks it as the sum of the stages above.
  - nxt outside IDLE is ignored: not queued, does not restart.
- SPI transaction timing, with divider div of SCLK_DIV_W bits cleared when SS_n falls:
  - SCLK = 1 while div < 2^(W-1), else 0; first falling edge 16 clks after SS_n falls (default W).
  - Rising edge occurs at div wrap (all ones -> 0).
  - MOSI = bit15 of the command in the same clk SS_n falls.
  - MOSI shifts to the next bit on every SCLK falling edge except the first.
  - MISO is sampled into rx (MSB first) on every SCLK rising edge.
  - After the 16th rising edge, SCLK is held high and SS_n rises on the next clk.
  - SS_n low time = 16*2^W + 1 clks (513 default).
  - MOSI returns to 0 while SS_n is high.
- Output stability: data outputs change only in DONE; all other outputs hold their registered values.

Test Plan:
- Reset: assert rst for 2 clks with MISO toggling -> all readings 12'h000, SS_n=1, SCLK=1, cnv_cmplt=0; nxt with rst high has no effect.
- Single conversion: A2D model returns 16'h0ABC in TX2 -> MOSI carries 16'h0000 in both transactions, SS_n low 513 clks each with a 2-clk gap, lft_ld=12'hABC, one cnv_cmplt pulse, other outputs unchanged.
- Round robin and wrap: 5 spaced nxt pulses with responses 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555 -> commands 16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000; lft_ld ends 12'h555, rght_ld 12'h222, steer_pot 12'h333, batt 12'h444.
- Busy request: nxt pulses at clk 100 of TX1 and during GAP -> exactly one conversion and one cnv_cmplt; rr advances by 1.
- Upper bits: response 16'hF123 on the rght_ld slot -> rght_ld=12'h123.
- Reset mid-TX2: rst at clk 300 of TX2 -> next clk SS_n=1, SCLK=1; all outputs 12'h000; the following nxt converts channel 0 (command 16'h0000).
